// File: rtl/quadrature_step_decoder.sv
// Quadrature front-end: synchronises and glitch-filters two encoder channels, then
// turns legal Gray-code moves into a step pulse plus direction for an up/down counter.
module quadrature_step_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic enc_a,
   input  logic enc_b,
   input  logic err_clr,
   output logic step,
   output logic updown,
   output logic err,
   output logic err_flag,
   output logic ready
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
   localparam int WARM_W = $clog2(SYNC_STAGES + 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

   typedef enum logic {
      ST_INIT,
      ST_TRACK
   } state_t;

   logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
   logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
   logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;
   logic                   a_f_q, a_f_d;
   logic                   b_f_q, b_f_d;
   logic [1:0]             prev_q, prev_d;
   logic [WARM_W-1:0]      warm_q, warm_d;
   logic [CNT_W-1:0]       stable_q, stable_d;
   state_t                 state_q, state_d;
   logic                   step_q, step_d;
   logic                   err_q, err_d;
   logic                   updown_q, updown_d;
   logic                   err_flag_q, err_flag_d;

   logic                   synced_a;
   logic                   synced_b;
   logic                   both_equal;
   logic [1:0]             acc;

   always_comb begin
      sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
      sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
      synced_a = sync_a_q[SYNC_STAGES-1];
      synced_b = sync_b_q[SYNC_STAGES-1];
   end

   // A channel's accepted level only moves after FILTER_LEN consecutive differing samples.
   always_comb begin
      cnt_a_d = '0;
      a_f_d   = a_f_q;
      if (synced_a != a_f_q) begin
         if (cnt_a_q == CNT_LAST) begin
            a_f_d = synced_a;
         end else begin
            cnt_a_d = cnt_a_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      cnt_b_d = '0;
      b_f_d   = b_f_q;
      if (synced_b != b_f_q) begin
         if (cnt_b_q == CNT_LAST) begin
            b_f_d = synced_b;
         end else begin
            cnt_b_d = cnt_b_q + CNT_W'(1);
         end
      end
   end

   // INIT first lets the synchroniser flush its reset zeros, then waits for a settled input.
   always_comb begin
      both_equal = (synced_a == a_f_q) && (synced_b == b_f_q);
      acc        = {a_f_q, b_f_q};
      state_d    = state_q;
      warm_d     = warm_q;
      stable_d   = stable_q;
      step_d     = 1'b0;
      err_d      = 1'b0;
      updown_d   = updown_q;
      prev_d     = acc;
      case (state_q)
         ST_INIT: begin
            if (warm_q != WARM_LAST) begin
               warm_d = warm_q + WARM_W'(1);
            end else if (!both_equal) begin
               stable_d = '0;
            end else if (stable_q == CNT_LAST) begin
               stable_d = '0;
               state_d  = ST_TRACK;
            end else begin
               stable_d = stable_q + CNT_W'(1);
            end
         end
         ST_TRACK: begin
            if (acc != prev_q) begin
               if (^(acc ^ prev_q)) begin
                  // In the 00->01->11->10 cycle a forward move has new B differing from old A.
                  step_d   = 1'b1;
                  updown_d = prev_q[1] ^ acc[0];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      err_flag_d = err_d | (err_flag_q & ~err_clr);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         sync_a_q   <= '0;
         sync_b_q   <= '0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         a_f_q      <= 1'b0;
         b_f_q      <= 1'b0;
         prev_q     <= 2'b00;
         warm_q     <= '0;
         stable_q   <= '0;
         state_q    <= ST_INIT;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
         updown_q   <= 1'b1;
         err_flag_q <= 1'b0;
      end else begin
         sync_a_q   <= sync_a_d;
         sync_b_q   <= sync_b_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         a_f_q      <= a_f_d;
         b_f_q      <= b_f_d;
         prev_q     <= prev_d;
         warm_q     <= warm_d;
         stable_q   <= stable_d;
         state_q    <= state_d;
         step_q     <= step_d;
         err_q      <= err_d;
         updown_q   <= updown_d;
         err_flag_q <= err_flag_d;
      end
   end

   assign step     = step_q;
   assign err      = err_q;
   assign updown   = updown_q;
   assign err_flag = err_flag_q;
   assign ready    = (state_q == ST_TRACK);

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Scoreboard bench: stimulus queues the expected step/err events with their due cycle,
// a negedge monitor pops and compares whenever the decoder pulses.
module tb_quadrature_step_decoder;

   logic clock = 1'b0;
   logic clear = 1'b1;
   logic enc_a = 1'b0;
   logic enc_b = 1'b0;
   logic err_clr = 1'b0;
   logic step;
   logic updown;
   logic err;
   logic err_flag;
   logic ready;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      bit is_err;
      bit dir;
      int due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   quadrature_step_decoder #(
      .SYNC_STAGES(2),
      .FILTER_LEN (4)
   ) dut (
      .clock   (clock),
      .clear   (clear),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .err_clr (err_clr),
      .step    (step),
      .updown  (updown),
      .err     (err),
      .err_flag(err_flag),
      .ready   (ready)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0b expected %0b at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // A level change sampled at the next edge reaches step/err seven edges later.
   task automatic apply_stimulus(input logic [1:0] ab, input bit expect_pulse,
                                 input bit is_err, input bit dir);
      exp_t e;
      {enc_a, enc_b} = ab;
      if (expect_pulse) begin
         e.is_err = is_err;
         e.dir    = dir;
         e.due    = cyc + 7;
         exp_q.push_back(e);
      end
   endtask

   always @(negedge clock) begin
      if (step === 1'b1 || err === 1'b1) begin
         checks++;
         if (step === 1'b1 && err === 1'b1) begin
            errors++;
            $display("[TB] FAIL pulse_overlap: step=%0b err=%0b both high at cycle %0d", step, err, cyc);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pulse: step=%0b err=%0b at cycle %0d, expected none", step, err, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if ((err !== logic'(mon_e.is_err)) || (mon_e.due != cyc) ||
                (!mon_e.is_err && updown !== logic'(mon_e.dir))) begin
               errors++;
               $display("[TB] FAIL event: got step=%0b err=%0b updown=%0b cycle=%0d expected err=%0b updown=%0b cycle=%0d",
                        step, err, updown, cyc, mon_e.is_err, mon_e.dir, mon_e.due);
            end
         end
      end
   end

   initial begin
      // Reset with encoder idle at 00
      clear = 1'b1;
      {enc_a, enc_b} = 2'b00;
      tick(3);
      clear = 1'b0;
      check_output("reset_step", step, 1'b0);
      check_output("reset_err", err, 1'b0);
      check_output("reset_err_flag", err_flag, 1'b0);
      check_output("reset_updown", updown, 1'b1);
      check_output("reset_ready", ready, 1'b0);
      tick(5);
      check_output("ready_early", ready, 1'b0);
      tick(1);
      check_output("ready_on_time", ready, 1'b1);
      tick(2);

      // Full up cycle
      apply_stimulus(2'b01, 1'b1, 1'b0, 1'b1); tick(10);
      apply_stimulus(2'b11, 1'b1, 1'b0, 1'b1); tick(10);
      apply_stimulus(2'b10, 1'b1, 1'b0, 1'b1); tick(10);
      apply_stimulus(2'b00, 1'b1, 1'b0, 1'b1); tick(10);
      check_output("updown_after_up", updown, 1'b1);

      // Full down cycle, then one up move
      apply_stimulus(2'b10, 1'b1, 1'b0, 1'b0); tick(10);
      apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0); tick(10);
      apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0); tick(10);
      apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0); tick(10);
      check_output("updown_held_down", updown, 1'b0);
      apply_stimulus(2'b01, 1'b1, 1'b0, 1'b1); tick(10);
      check_output("updown_back_up", updown, 1'b1);

      // Three-cycle glitch on channel A is swallowed; accepted state stays 01
      apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0); tick(3);
      apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0); tick(12);
      check_output("glitch_no_err", err_flag, 1'b0);
      apply_stimulus(2'b11, 1'b1, 1'b0, 1'b1); tick(10);

      // Two down moves, then an illegal double jump
      apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0); tick(10);
      apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0); tick(10);
      apply_stimulus(2'b11, 1'b1, 1'b1, 1'b0); tick(10);
      check_output("err_flag_set", err_flag, 1'b1);
      check_output("updown_kept_on_err", updown, 1'b0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check_output("err_flag_cleared", err_flag, 1'b0);

      // err_clr held across the edge where the next error lands
      apply_stimulus(2'b00, 1'b1, 1'b1, 1'b0);
      tick(4);
      err_clr = 1'b1;
      tick(3);
      err_clr = 1'b0;
      check_output("err_set_wins", err_flag, 1'b1);
      tick(5);

      // Clear mid-filter, power back up with encoder at 11
      apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0);
      tick(2);
      clear = 1'b1;
      {enc_a, enc_b} = 2'b11;
      tick(1);
      clear = 1'b0;
      check_output("midclear_ready", ready, 1'b0);
      check_output("midclear_err_flag", err_flag, 1'b0);
      check_output("midclear_updown", updown, 1'b1);
      check_output("midclear_step", step, 1'b0);
      tick(9);
      check_output("powerup11_ready_early", ready, 1'b0);
      tick(1);
      check_output("powerup11_ready", ready, 1'b1);
      tick(3);
      apply_stimulus(2'b10, 1'b1, 1'b0, 1'b1);
      tick(12);

      while (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL missing_event: got no pulse, expected err=%0b updown=%0b at cycle %0d",
                  mon_e.is_err, mon_e.dir, mon_e.due);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
